// File: rtl/ram_reset_pkg.sv
// Shared definitions for the SDRAM PLL reset/power-up sequencer.
// Covers state encodings, default 48 MHz cycle budgets and retry counter helpers.
package ram_reset_pkg;

    localparam logic [2:0] ST_PLLRST   = 3'd0;
    localparam logic [2:0] ST_WAITLOCK = 3'd1;
    localparam logic [2:0] ST_STABLE   = 3'd2;
    localparam logic [2:0] ST_PWRUP    = 3'd3;
    localparam logic [2:0] ST_RUN      = 3'd4;

    // Default cycle budgets, counted on the 48 MHz board clock.
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 48000;
    localparam int DEF_PWRUP_CYCLES        = 9600;
    localparam int DEF_CNT_W               = 16;

    localparam int RETRY_W = 4;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
        return (&v) ? v : v + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Generic N-flop single-bit synchroniser with synchronous active-high reset to 0.
// Also reused by the highClk/sdramClk consumers of sysReset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_stages_check
        $error("bit_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ram_reset_seq.sv
// Reset/power-up sequencer downstream of the SDRAM PLL, clocked by the 48 MHz board clock.
// Pulses the PLL reset, waits for stable lock and the SDRAM power-up delay, then releases sysReset.
module ram_reset_seq
    import ram_reset_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int PWRUP_CYCLES        = DEF_PWRUP_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               locked,
    output logic               pllReset,
    output logic               sysReset,
    output logic               ready,
    output logic               sdramInitReq,
    output logic [RETRY_W-1:0] retryCount,
    output logic [2:0]         state
);

    localparam int MAX_CYCLES = max4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES, PWRUP_CYCLES);

    if ((longint'(MAX_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
        $error("ram_reset_seq: CNT_W too narrow for the largest cycle parameter");
    end

    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);

    logic               lock_sync;
    logic [2:0]         state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [RETRY_W-1:0] retry_q,     retry_d;
    logic               pll_reset_q, pll_reset_d;
    logic               sys_reset_q, sys_reset_d;
    logic               ready_q,     ready_d;
    logic               init_req_q,  init_req_d;

    // locked is asynchronous to clkin; the FSM only ever looks at lock_sync.
    bit_sync #(.STAGES(2)) u_lock_sync (
        .clk   (clkin),
        .reset (reset),
        .d     (locked),
        .q     (lock_sync)
    );

    // NOTE: every signal gets a default before the case, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        init_req_d = 1'b0;

        case (state_q)
            ST_PLLRST: begin
                if (cnt_q == PLL_LAST) begin
                    state_d = ST_WAITLOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAITLOCK: begin
                if (lock_sync) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_PLLRST;
                    cnt_d   = '0;
                    retry_d = retry_inc(retry_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                // A lock drop here is treated as a glitch: re-wait for lock, no retry.
                if (!lock_sync) begin
                    state_d = ST_WAITLOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_PWRUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PWRUP: begin
                if (!lock_sync) begin
                    state_d = ST_PLLRST;
                    cnt_d   = '0;
                    retry_d = retry_inc(retry_q);
                end else if (cnt_q == PWRUP_LAST) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    init_req_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_sync) begin
                    state_d = ST_PLLRST;
                    cnt_d   = '0;
                    retry_d = retry_inc(retry_q);
                end
            end
            default: begin
                state_d = ST_PLLRST;
                cnt_d   = '0;
            end
        endcase

        // Outputs decode the next state so they change on the same edge as state_q.
        pll_reset_d = (state_d == ST_PLLRST);
        sys_reset_d = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= ST_PLLRST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            init_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            init_req_q  <= init_req_d;
        end
    end

    assign pllReset     = pll_reset_q;
    assign sysReset     = sys_reset_q;
    assign ready        = ready_q;
    assign sdramInitReq = init_req_q;
    assign retryCount   = retry_q;
    assign state        = state_q;

endmodule

// File: doc/ram_reset_seq.md
Name: ram_reset_seq

Overview:
- Reset/power-up sequencer directly downstream of the SDRAM PLL (48 MHz in, 100 MHz CLKOP, 50 MHz CLKOS).
- Drives the PLL reset input and consumes its lock output.
- Holds system reset until lock has been stable long enough and the SDRAM power-up wait (200 us) has elapsed, then requests SDRAM initialisation.
- Runs on the always-running 48 MHz board clock so it keeps working while the PLL is in reset. Consumers in highClk/sdramClk domains resynchronise sysReset and ready themselves.

Parameters:
PLL_RST_CYCLES, 16, cycles pllReset is held high per PLL reset attempt
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before power-up wait
LOCK_TIMEOUT_CYCLES, 48000, cycles in WAITLOCK (1 ms) before re-resetting the PLL
PWRUP_CYCLES, 9600, SDRAM power-up wait in cycles (200 us at 48 MHz)
CNT_W, 16, shared down-phase counter width; must hold the largest cycle parameter minus 1 (elaboration assertion)

Ports:
clkin  in  1  48 MHz board clock; the only clock
reset  in  1  synchronous, active-high
locked  in  1  PLL LOCK, asynchronous to clkin
pllReset  out  1  to PLL RST, active-high
sysReset  out  1  active-high system/SDRAM-controller reset
ready  out  1  high while in RUN
sdramInitReq  out  1  single-cycle pulse on entry to RUN
retryCount  out  4  saturating count of PLL re-reset events
state  out  3  debug: current state encoding

Behaviour:
- Clocking and outputs:
  - All logic on rising clkin.
  - Every output is a registered, glitch-free flop, loaded from next-state decode. Outputs change on the same edge as the state.
- Synchroniser:
  - locked passes through a 2-flop synchroniser (lockSync), reset to 0.
  - A change on locked is therefore first visible to the FSM 2 cycles later.
- Reset (reset=1 at an edge):
  - state=PLLRST, cnt=0, lockSync=0, retryCount=0.
  - pllReset=1, sysReset=1, ready=0, sdramInitReq=0.
  - This applies in any state, including mid-sequence.
- States (encoding 0..4): PLLRST, WAITLOCK, STABLE, PWRUP, RUN.
- PLLRST:
  - pllReset=1 and lockSync is ignored.
  - cnt increments. At cnt==PLL_RST_CYCLES-1: go to WAITLOCK, cnt=0.
  - pllReset is therefore high for exactly PLL_RST_CYCLES cycles.
- WAITLOCK:
  - If lockSync=1: go to STABLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1: go to PLLRST, cnt=0, retryCount+1.
  - Else cnt++.
- STABLE:
  - If lockSync=0: go to WAITLOCK, cnt=0. This is a glitch, not a retry; retryCount is unchanged.
  - Else if cnt==LOCK_STABLE_CYCLES-1: go to PWRUP, cnt=0.
  - Else cnt++.
- PWRUP:
  - If lockSync=0: go to PLLRST, cnt=0, retryCount+1.
  - Else if cnt==PWRUP_CYCLES-1: go to RUN, and sdramInitReq=1 for that one cycle.
  - Else cnt++.
- RUN:
  - sysReset=0, ready=1. sdramInitReq=1 only on the entry cycle.
  - If lockSync=0: go to PLLRST, retryCount+1. sysReset=1 and ready=0 on that same edge.
- Output decode:
  - sysReset=1 in every state except RUN.
  - pllReset=1 only in PLLRST.
- retryCount:
  - Saturates at 15 and never wraps.
  - Cleared only by reset.
- Latency: locked rising (then held) to ready = 2 + 1 + LOCK_STABLE_CYCLES + PWRUP_CYCLES cycles.
- Simultaneous events:
  - reset has priority over everything.
  - Loss of lock has priority over counter terminal in STABLE and PWRUP.
  - In WAITLOCK, lockSync=1 beats the timeout on the same cycle.

Decomposition:
- Package ram_reset_pkg:
  - 3-bit state encodings ST_PLLRST..ST_RUN.
  - Default cycle constants for 48 MHz.
  - RETRY_W=4.
- Sub-module bit_sync: generic N-flop (default 2) synchroniser with synchronous active-high reset to 0. Reused by highClk/sdramClk consumers of sysReset.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, PWRUP_CYCLES=16.
1. Reset 3 cycles, release, locked=0 -> pllReset=1 for exactly 4 cycles after release, then 0; sysReset=1; ready=0; state=WAITLOCK.
2. Then raise locked and hold -> ready and sdramInitReq rise exactly 27 cycles after locked; sdramInitReq high for one cycle; sysReset=0 on the same edge; retryCount=0.
3. locked low for 1 cycle midway through STABLE -> state returns to WAITLOCK; ready delayed by the restarted 8+16 count; retryCount stays 0.
4. locked held 0 forever -> PLLRST re-entered every 36 cycles; retryCount steps 1,2,… and saturates at 15 after the 15th timeout, never wraps.
5. In RUN, drop locked -> 3 cycles later sysReset=1, ready=0, pllReset=1 for 4 cycles, retryCount=1; relock -> ready returns after another 27 cycles.
6. Assert reset for 1 cycle mid-PWRUP -> next edge state=PLLRST, pllReset=1, sysReset=1, ready=0, retryCount=0; full sequence repeats.
